// File: rtl/wb_write_queue_if.sv
// Bundle of producer, register-file and bypass-lookup signals for wb_write_queue.
// master: the environment side (producers, lookup requester, regfile sink).
// slave:  the queue itself.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

interface wb_write_queue_if #(
  parameter int WORD_WIDTH = `WORD_WIDTH,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  memValid;
  logic [4:0]            memAddr;
  logic [WORD_WIDTH-1:0] memData;
  logic                  memReady;
  logic                  aluValid;
  logic [4:0]            aluAddr;
  logic [WORD_WIDTH-1:0] aluData;
  logic                  aluReady;
  logic [4:0]            regWriteAddr;
  logic [WORD_WIDTH-1:0] dataToWrite;
  logic                  toWrite;
  logic [4:0]            lookupAddr1;
  logic [4:0]            lookupAddr2;
  logic                  lookupHit1;
  logic [WORD_WIDTH-1:0] lookupData1;
  logic                  lookupHit2;
  logic [WORD_WIDTH-1:0] lookupData2;
  logic [CW-1:0]         count;

  modport master (
    output memValid, memAddr, memData, aluValid, aluAddr, aluData, lookupAddr1, lookupAddr2,
    input  memReady, aluReady, regWriteAddr, dataToWrite, toWrite,
           lookupHit1, lookupData1, lookupHit2, lookupData2, count
  );

  modport slave (
    input  memValid, memAddr, memData, aluValid, aluAddr, aluData, lookupAddr1, lookupAddr2,
    output memReady, aluReady, regWriteAddr, dataToWrite, toWrite,
           lookupHit1, lookupData1, lookupHit2, lookupData2, count
  );
endinterface

// File: rtl/wb_write_queue.sv
// In-order write-back queue: takes results from the load unit and the ALU,
// buffers them, and retires one entry per cycle to the register-file write port.
// Optional feature macro: WB_BYPASS_EN enables the pending-value bypass search;
// without it the lookup outputs are tied to zero.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module wb_write_queue #(
  parameter int WORD_WIDTH = `WORD_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic              clk,
  input  logic              rst,
  wb_write_queue_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]            q_addr [DEPTH];
  logic [WORD_WIDTH-1:0] q_data [DEPTH];
  logic [PW-1:0]         head, tail;
  logic [CW-1:0]         count;

  logic [CW-1:0] free;
  logic          mem_acc, alu_acc, deq;
  logic [PW-1:0] alu_idx;
  logic [CW-1:0] enq_n;

  // Readiness depends only on occupancy at cycle start; the retiring head does
  // not make room for a same-cycle enqueue, keeping ready off the drain path.
  assign free         = CW'(DEPTH) - count;
  assign bus.memReady = (free >= CW'(1));
  assign bus.aluReady = bus.memValid ? (free >= CW'(2)) : (free >= CW'(1));

  // Writes to r0 complete the handshake but are dropped.
  assign mem_acc = bus.memValid && bus.memReady && (bus.memAddr != 5'd0);
  assign alu_acc = bus.aluValid && bus.aluReady && (bus.aluAddr != 5'd0);
  assign deq     = (count != '0);

  // Load result is older than a same-cycle ALU result, so it takes the first slot.
  assign alu_idx = tail + PW'(mem_acc);
  assign enq_n   = CW'(mem_acc) + CW'(alu_acc);

  assign bus.toWrite      = deq;
  assign bus.regWriteAddr = deq ? q_addr[head] : 5'd0;
  assign bus.dataToWrite  = deq ? q_data[head] : '0;
  assign bus.count        = count;

  // Pointer and occupancy bookkeeping; full/empty come from count alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(deq);
      tail  <= tail + PW'(enq_n);
      count <= count + enq_n - CW'(deq);
    end
  end

  // Entry storage; contents are only meaningful within [head, head+count).
  always_ff @(posedge clk) begin
    if (mem_acc) begin
      q_addr[tail] <= bus.memAddr;
      q_data[tail] <= bus.memData;
    end
    if (alu_acc) begin
      q_addr[alu_idx] <= bus.aluAddr;
      q_data[alu_idx] <= bus.aluData;
    end
  end

`ifdef WB_BYPASS_EN
  logic                  hit1, hit2;
  logic [WORD_WIDTH-1:0] data1, data2;

  // Walk entries oldest to youngest so the last match (youngest) wins.
  always_comb begin
    hit1  = 1'b0;
    hit2  = 1'b0;
    data1 = '0;
    data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) begin
        if ((bus.lookupAddr1 != 5'd0) && (q_addr[head + PW'(i)] == bus.lookupAddr1)) begin
          hit1  = 1'b1;
          data1 = q_data[head + PW'(i)];
        end
        if ((bus.lookupAddr2 != 5'd0) && (q_addr[head + PW'(i)] == bus.lookupAddr2)) begin
          hit2  = 1'b1;
          data2 = q_data[head + PW'(i)];
        end
      end
    end
  end

  assign bus.lookupHit1  = hit1;
  assign bus.lookupData1 = data1;
  assign bus.lookupHit2  = hit2;
  assign bus.lookupData2 = data2;
`else
  logic unused_lookup;
  assign unused_lookup   = ^{bus.lookupAddr1, bus.lookupAddr2};
  assign bus.lookupHit1  = 1'b0;
  assign bus.lookupData1 = '0;
  assign bus.lookupHit2  = 1'b0;
  assign bus.lookupData2 = '0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue (DEPTH=4, 32-bit data): a table of
// per-cycle vectors plus a hand-written reset-while-busy sequence.
module tb_wb_write_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  wb_write_queue_if #(.WORD_WIDTH(32), .DEPTH(4)) bus ();
  wb_write_queue #(.WORD_WIDTH(32), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic mv; logic [4:0] ma; logic [31:0] md;
    logic av; logic [4:0] aa; logic [31:0] ad;
    logic [4:0] l1; logic [4:0] l2;
    logic tw; logic [4:0] wa; logic [31:0] wd;
    logic mr; logic ar; logic [2:0] cnt;
    logic h1; logic [31:0] d1; logic h2; logic [31:0] d2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic mv, logic [4:0] ma, logic [31:0] md, logic av, logic [4:0] aa, logic [31:0] ad,
    logic [4:0] l1, logic [4:0] l2, logic tw, logic [4:0] wa, logic [31:0] wd,
    logic mr, logic ar, logic [2:0] cnt, logic h1, logic [31:0] d1, logic h2, logic [31:0] d2);
    vec_t v;
    v.mv = mv; v.ma = ma; v.md = md; v.av = av; v.aa = aa; v.ad = ad;
    v.l1 = l1; v.l2 = l2; v.tw = tw; v.wa = wa; v.wd = wd;
    v.mr = mr; v.ar = ar; v.cnt = cnt; v.h1 = h1; v.d1 = d1; v.h2 = h2; v.d2 = d2;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic mv, logic [4:0] ma, logic [31:0] md,
                       logic av, logic [4:0] aa, logic [31:0] ad,
                       logic [4:0] l1, logic [4:0] l2);
    bus.memValid = mv; bus.memAddr = ma; bus.memData = md;
    bus.aluValid = av; bus.aluAddr = aa; bus.aluData = ad;
    bus.lookupAddr1 = l1; bus.lookupAddr2 = l2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset / single ALU write
    vecs.push_back(mk(0,0,0,        0,0,0,          0,0, 0,0,0,        1,1,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,        1,8,'h11,       0,0, 0,0,0,        1,1,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,        0,0,0,          8,0, 1,8,'h11,     1,1,1, 1,'h11,0,0));
    vecs.push_back(mk(0,0,0,        0,0,0,          8,0, 0,0,0,        1,1,0, 0,0,0,0));
    // Dual accept, mem older
    vecs.push_back(mk(1,9,'hA,      1,10,'hB,       0,0, 0,0,0,        1,1,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,        0,0,0,          0,10,1,9,'hA,      1,1,2, 0,0,1,'hB));
    vecs.push_back(mk(0,0,0,        0,0,0,          0,0, 1,10,'hB,     1,1,1, 0,0,0,0));
    vecs.push_back(mk(0,0,0,        0,0,0,          0,0, 0,0,0,        1,1,0, 0,0,0,0));
    // Near-full with drain: ALU held at count 3
    vecs.push_back(mk(1,1,'h101,    1,2,'h102,      0,0, 0,0,0,        1,1,0, 0,0,0,0));
    vecs.push_back(mk(1,3,'h103,    1,4,'h104,      0,0, 1,1,'h101,    1,1,2, 0,0,0,0));
    vecs.push_back(mk(1,5,'h105,    1,6,'h106,      0,0, 1,2,'h102,    1,0,3, 0,0,0,0));
    vecs.push_back(mk(0,0,0,        1,6,'h106,      0,0, 1,3,'h103,    1,1,3, 0,0,0,0));
    vecs.push_back(mk(0,0,0,        0,0,0,          6,5, 1,4,'h104,    1,1,3, 1,'h106,1,'h105));
    vecs.push_back(mk(0,0,0,        0,0,0,          0,0, 1,5,'h105,    1,1,2, 0,0,0,0));
    vecs.push_back(mk(0,0,0,        0,0,0,          0,0, 1,6,'h106,    1,1,1, 0,0,0,0));
    vecs.push_back(mk(0,0,0,        0,0,0,          0,0, 0,0,0,        1,1,0, 0,0,0,0));
    // Register 0 writes are dropped
    vecs.push_back(mk(0,0,0,        1,0,'hFFFFFFFF, 0,0, 0,0,0,        1,1,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,        0,0,0,          0,0, 0,0,0,        1,1,0, 0,0,0,0));
    vecs.push_back(mk(1,0,'h55,     1,7,'h77,       0,0, 0,0,0,        1,1,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,        0,0,0,          0,0, 1,7,'h77,     1,1,1, 0,0,0,0));
    // Bypass: youngest of two entries to r8
    vecs.push_back(mk(1,8,'h1,      1,8,'h2,        0,0, 0,0,0,        1,1,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,        0,0,0,          8,0, 1,8,'h1,      1,1,2, 1,'h2,0,0));
    vecs.push_back(mk(0,0,0,        0,0,0,          8,0, 1,8,'h2,      1,1,1, 1,'h2,0,0));
    vecs.push_back(mk(0,0,0,        0,0,0,          8,0, 0,0,0,        1,1,0, 0,0,0,0));

    drive(0,0,0,0,0,0,0,0);
    rst = 1'b1;
    #1;
    chk("rst_towrite", 32'(bus.toWrite), 0);
    chk("rst_count", 32'(bus.count), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      drive(v.mv, v.ma, v.md, v.av, v.aa, v.ad, v.l1, v.l2);
      #1;
      chk($sformatf("v%0d_towrite", i), 32'(bus.toWrite), 32'(v.tw));
      chk($sformatf("v%0d_waddr", i), 32'(bus.regWriteAddr), 32'(v.wa));
      chk($sformatf("v%0d_wdata", i), bus.dataToWrite, v.wd);
      chk($sformatf("v%0d_memready", i), 32'(bus.memReady), 32'(v.mr));
      chk($sformatf("v%0d_aluready", i), 32'(bus.aluReady), 32'(v.ar));
      chk($sformatf("v%0d_count", i), 32'(bus.count), 32'(v.cnt));
      chk($sformatf("v%0d_hit1", i), 32'(bus.lookupHit1), 32'(v.h1 & BYP));
      chk($sformatf("v%0d_data1", i), bus.lookupData1, BYP ? v.d1 : 32'd0);
      chk($sformatf("v%0d_hit2", i), 32'(bus.lookupHit2), 32'(v.h2 & BYP));
      chk($sformatf("v%0d_data2", i), bus.lookupData2, BYP ? v.d2 : 32'd0);
      @(negedge clk);
    end

    // Reset with three entries pending
    drive(1,11,'h21, 1,12,'h22, 0,0);
    @(negedge clk);
    drive(1,13,'h23, 1,14,'h24, 0,0);
    #1;
    chk("t6_count2", 32'(bus.count), 2);
    @(negedge clk);
    drive(0,0,0,0,0,0,0,0);
    #1;
    chk("t6_count3", 32'(bus.count), 3);
    chk("t6_head", 32'(bus.regWriteAddr), 12);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_towrite", 32'(bus.toWrite), 0);
    chk("t6_async_count", 32'(bus.count), 0);
    chk("t6_async_waddr", 32'(bus.regWriteAddr), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0,0,0, 1,15,'h25, 0,0);
    #1;
    chk("t6_rel_count", 32'(bus.count), 0);
    chk("t6_rel_towrite", 32'(bus.toWrite), 0);
    chk("t6_rel_aluready", 32'(bus.aluReady), 1);
    @(negedge clk);
    drive(0,0,0,0,0,0,0,0);
    #1;
    chk("t6_new_towrite", 32'(bus.toWrite), 1);
    chk("t6_new_waddr", 32'(bus.regWriteAddr), 15);
    chk("t6_new_wdata", bus.dataToWrite, 32'h25);
    @(negedge clk);
    #1;
    chk("t6_empty_towrite", 32'(bus.toWrite), 0);
    chk("t6_empty_count", 32'(bus.count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
